mem_write_checker: RTL and testbench

Synthesizable self-check monitor for the processor's data-memory write bus, replacing ad-hoc pass/fail checks in benches. It sits beside `top`, snoops `Adr`/`WriteData`/`MemWrite`, and classifies every write as pass, tolerated or fault. It latches a sticky verdict with a diagnostic code, the offending address and data, cycle and write counters, and an optional watchdog timeout. It works identically in simulation and on FPGA, where `done`/`pass` drive LEDs.

---
 rtl/mem_write_checker.sv | 148 ++++++++++++++
 tb/tb_mem_write_checker.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_checker.sv
// Snoops the data-memory write bus and latches a sticky pass/fail verdict
// with a diagnostic code, the faulting write, and cycle/write counters.
module mem_write_checker #(
    parameter int unsigned DW         = 32,
    parameter int unsigned AW         = 32,
    parameter int unsigned PASS_ADR   = 100,
    parameter int unsigned PASS_DATA  = 7,
    parameter int unsigned TOL_LO     = 96,
    parameter int unsigned TOL_HI     = 96,
    parameter int unsigned MAX_WRITES = 16,
    parameter int unsigned TIMEOUT    = 1000,
    parameter int unsigned CW         = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWrite,
    input  logic [AW-1:0] Adr,
    input  logic [DW-1:0] WriteData,
    output logic          done,
    output logic          pass,
    output logic [2:0]    code,
    output logic [AW-1:0] fail_adr,
    output logic [DW-1:0] fail_data,
    output logic [CW-1:0] cycle_count,
    output logic [CW-1:0] write_count
);

    typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL} state_t;

    localparam logic [2:0] CodePass     = 3'd1;
    localparam logic [2:0] CodeBadAdr   = 3'd2;
    localparam logic [2:0] CodeBadData  = 3'd3;
    localparam logic [2:0] CodeTimeout  = 3'd4;
    localparam logic [2:0] CodeOverflow = 3'd5;

    localparam logic [AW-1:0] PassAdr   = AW'(PASS_ADR);
    localparam logic [DW-1:0] PassData  = DW'(PASS_DATA);
    localparam logic [AW-1:0] TolLo     = AW'(TOL_LO);
    localparam logic [AW-1:0] TolHi     = AW'(TOL_HI);
    localparam logic [CW:0]   MaxWrites = (CW+1)'(MAX_WRITES);
    localparam int unsigned   TimeoutLimit = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    state_t        state_q, state_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [2:0]    code_q, code_d;
    logic [AW-1:0] failAdr_q, failAdr_d;
    logic [DW-1:0] failData_q, failData_d;
    logic [CW-1:0] cycleCount_q, cycleCount_d;
    logic [CW-1:0] writeCount_q, writeCount_d;

    logic [CW:0]   writeCountInc;
    logic          writeVerdict;

    always_comb begin
        state_d       = state_q;
        done_d        = done_q;
        pass_d        = pass_q;
        code_d        = code_q;
        failAdr_d     = failAdr_q;
        failData_d    = failData_q;
        cycleCount_d  = cycleCount_q;
        writeCount_d  = writeCount_q;
        writeCountInc = {1'b0, writeCount_q} + (CW+1)'(1);
        writeVerdict  = 1'b0;

        if (state_q == S_RUN) begin
            if (cycleCount_q != '1) begin
                cycleCount_d = cycleCount_q + 1'b1;
            end

            // Equality tests against unknown bits are not true, so an X/Z
            // address or data word falls through to the failing branch.
            if (MemWrite == 1'b1) begin
                if (Adr == PassAdr) begin
                    writeVerdict = 1'b1;
                    if (WriteData == PassData) begin
                        state_d = S_PASS;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                        code_d  = CodePass;
                    end else begin
                        state_d    = S_FAIL;
                        done_d     = 1'b1;
                        code_d     = CodeBadData;
                        failAdr_d  = Adr;
                        failData_d = WriteData;
                    end
                end else if ((Adr >= TolLo) && (Adr <= TolHi)) begin
                    writeCount_d = writeCountInc[CW-1:0];
                    if (writeCountInc > MaxWrites) begin
                        writeVerdict = 1'b1;
                        state_d      = S_FAIL;
                        done_d       = 1'b1;
                        code_d       = CodeOverflow;
                        failAdr_d    = Adr;
                        failData_d   = WriteData;
                    end
                end else begin
                    writeVerdict = 1'b1;
                    state_d      = S_FAIL;
                    done_d       = 1'b1;
                    code_d       = CodeBadAdr;
                    failAdr_d    = Adr;
                    failData_d   = WriteData;
                end
            end

            // A write verdict on this edge outranks the watchdog.
            if (!writeVerdict && (TIMEOUT != 0) && (32'(cycleCount_q) == TimeoutLimit)) begin
                state_d = S_FAIL;
                done_d  = 1'b1;
                code_d  = CodeTimeout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_RUN;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            code_q       <= 3'd0;
            failAdr_q    <= '0;
            failData_q   <= '0;
            cycleCount_q <= '0;
            writeCount_q <= '0;
        end else begin
            state_q      <= state_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            code_q       <= code_d;
            failAdr_q    <= failAdr_d;
            failData_q   <= failData_d;
            cycleCount_q <= cycleCount_d;
            writeCount_q <= writeCount_d;
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign code        = code_q;
    assign fail_adr    = failAdr_q;
    assign fail_data   = failData_q;
    assign cycle_count = cycleCount_q;
    assign write_count = writeCount_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Scoreboard bench: one main checker (TIMEOUT=50, MAX_WRITES=3) plus a
// narrow-counter checker with the watchdog disabled, sharing one bus.
module tb_mem_write_checker;

    typedef struct packed {
        logic        done;
        logic        pass;
        logic [2:0]  code;
        logic [31:0] fadr;
        logic [31:0] fdata;
        logic [15:0] cyc;
        logic [15:0] wr;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] Adr = '0;
    logic [31:0] WriteData = '0;

    logic        done, pass;
    logic [2:0]  code;
    logic [31:0] failAdr, failData;
    logic [15:0] cycleCount, writeCount;

    logic        satDone, satPass;
    logic [2:0]  satCode;
    logic [31:0] satFailAdr, satFailData;
    logic [3:0]  satCycleCount, satWriteCount;

    int total = 0;
    int bad = 0;
    obs_t expQ[$];

    always #5 clk = ~clk;

    mem_write_checker #(.MAX_WRITES(3), .TIMEOUT(50)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .Adr(Adr), .WriteData(WriteData),
        .done(done), .pass(pass), .code(code), .fail_adr(failAdr), .fail_data(failData),
        .cycle_count(cycleCount), .write_count(writeCount)
    );

    mem_write_checker #(.MAX_WRITES(3), .TIMEOUT(0), .CW(4)) dutSat (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .Adr(Adr), .WriteData(WriteData),
        .done(satDone), .pass(satPass), .code(satCode), .fail_adr(satFailAdr),
        .fail_data(satFailData), .cycle_count(satCycleCount), .write_count(satWriteCount)
    );

    function automatic obs_t mk(input logic d, input logic p, input logic [2:0] c,
                                input logic [31:0] fa, input logic [31:0] fd,
                                input logic [15:0] cy, input logic [15:0] w);
        obs_t o;
        o = '{done: d, pass: p, code: c, fadr: fa, fdata: fd, cyc: cy, wr: w};
        return o;
    endfunction

    function automatic obs_t sampleMain();
        return mk(done, pass, code, failAdr, failData, cycleCount, writeCount);
    endfunction

    function automatic obs_t sampleSat();
        return mk(satDone, satPass, satCode, satFailAdr, satFailData,
                  {12'd0, satCycleCount}, {12'd0, satWriteCount});
    endfunction

    function automatic string show(input obs_t o);
        return $sformatf("done=%0d pass=%0d code=%0d adr=%0d data=%0d cyc=%0d wr=%0d",
                         o.done, o.pass, o.code, o.fadr, o.fdata, o.cyc, o.wr);
    endfunction

    // Drive one bus cycle at the falling edge and sample just after the rising edge.
    task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemWrite  = mw;
        Adr       = a;
        WriteData = d;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
    endtask

    task automatic doReset(input int edges, input logic mw);
        @(negedge clk);
        reset     = 1'b1;
        MemWrite  = mw;
        Adr       = 32'd100;
        WriteData = 32'd7;
        repeat (edges) @(posedge clk);
        #1;
        reset    = 1'b0;
        MemWrite = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        doReset(2, 1'b1);
        expQ.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        got = sampleMain();
        exp = expQ.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL reset_main: got %s want %s", show(got), show(exp));
        end
        expQ.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        got = sampleSat();
        exp = expQ.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL reset_sat: got %s want %s", show(got), show(exp));
        end
    endtask

    task automatic test_pass();
        logic [31:0] adrs [3] = '{32'd96, 32'd100, 32'd100};
        logic [31:0] dats [3] = '{32'd5, 32'd7, 32'd9};
        obs_t got, exp;
        expQ.push_back(mk(0, 0, 0, 0, 0, 1, 1));
        expQ.push_back(mk(1, 1, 1, 0, 0, 2, 1));
        expQ.push_back(mk(1, 1, 1, 0, 0, 2, 1));
        for (int i = 0; i < 3; i++) begin
            step(1'b1, adrs[i], dats[i]);
            got = sampleMain();
            exp = expQ.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL pass_seq[%0d]: got %s want %s", i, show(got), show(exp));
            end
        end
    endtask

    task automatic test_bad_data();
        logic [31:0] adrs [3] = '{32'd100, 32'd104, 32'd100};
        logic [31:0] dats [3] = '{32'd8, 32'd7, 32'd7};
        obs_t got, exp;
        doReset(1, 1'b0);
        for (int i = 0; i < 3; i++) expQ.push_back(mk(1, 0, 3, 100, 8, 1, 0));
        for (int i = 0; i < 3; i++) begin
            step(1'b1, adrs[i], dats[i]);
            got = sampleMain();
            exp = expQ.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL bad_data[%0d]: got %s want %s", i, show(got), show(exp));
            end
        end
    endtask

    task automatic test_bad_adr();
        logic [31:0] adrs [3] = '{32'd104, 32'd95, 32'd97};
        obs_t got, exp;
        for (int i = 0; i < 3; i++) begin
            doReset(1, 1'b0);
            step(1'b0, 32'd0, 32'd0);
            expQ.push_back(mk(1, 0, 2, adrs[i], 32'd7 + i, 2, 0));
            step(1'b1, adrs[i], 32'd7 + i);
            got = sampleMain();
            exp = expQ.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL bad_adr[%0d]: got %s want %s", i, show(got), show(exp));
            end
        end
    endtask

    task automatic test_timeout();
        obs_t got, exp;
        doReset(1, 1'b0);
        repeat (48) step(1'b0, 32'd0, 32'd0);
        expQ.push_back(mk(0, 0, 0, 0, 0, 49, 0));
        expQ.push_back(mk(1, 0, 4, 0, 0, 50, 0));
        expQ.push_back(mk(1, 0, 4, 0, 0, 50, 0));
        for (int i = 0; i < 3; i++) begin
            step(i == 2, 32'd104, 32'd1);
            got = sampleMain();
            exp = expQ.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL timeout[%0d]: got %s want %s", i, show(got), show(exp));
            end
        end
    endtask

    task automatic test_priority();
        obs_t got, exp;
        doReset(1, 1'b0);
        repeat (49) step(1'b0, 32'd0, 32'd0);
        expQ.push_back(mk(1, 1, 1, 0, 0, 50, 0));
        step(1'b1, 32'd100, 32'd7);
        got = sampleMain();
        exp = expQ.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL priority: got %s want %s", show(got), show(exp));
        end
    endtask

    task automatic test_overflow();
        obs_t got, exp;
        doReset(1, 1'b0);
        for (int i = 1; i <= 3; i++) expQ.push_back(mk(0, 0, 0, 0, 0, 16'(i), 16'(i)));
        expQ.push_back(mk(1, 0, 5, 96, 4, 4, 4));
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 32'd96, 32'(i));
            got = sampleMain();
            exp = expQ.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL overflow[%0d]: got %s want %s", i, show(got), show(exp));
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t got, exp;
        doReset(1, 1'b0);
        step(1'b1, 32'd200, 32'd3);
        doReset(1, 1'b0);
        expQ.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        expQ.push_back(mk(1, 1, 1, 0, 0, 1, 0));
        for (int i = 0; i < 2; i++) begin
            if (i == 1) step(1'b1, 32'd100, 32'd7);
            got = sampleMain();
            exp = expQ.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL back_to_back[%0d]: got %s want %s", i, show(got), show(exp));
            end
        end
    endtask

    task automatic test_saturate();
        obs_t got, exp;
        doReset(1, 1'b0);
        repeat (20) step(1'b0, 32'd0, 32'd0);
        expQ.push_back(mk(0, 0, 0, 0, 0, 15, 0));
        expQ.push_back(mk(1, 1, 1, 0, 0, 15, 0));
        for (int i = 0; i < 2; i++) begin
            if (i == 1) step(1'b1, 32'd100, 32'd7);
            got = sampleSat();
            exp = expQ.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL saturate[%0d]: got %s want %s", i, show(got), show(exp));
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        test_reset();
        test_pass();
        test_bad_data();
        test_bad_adr();
        test_timeout();
        test_priority();
        test_overflow();
        test_back_to_back();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
